// File: rtl/viterbi_frame_ctrl_if.sv
// Handshake and datapath-control bundle between the Viterbi frame sequencer and its neighbours.
// The master side is the sequencer; the slave side is the symbol source, datapath and bit sink.
interface viterbi_frame_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        rx_pair;
  logic [1:0]        bmc_rx_pair;
  logic              metric_clr;
  logic              acs_en;
  logic              surv_wr_en;
  logic [ADDR_W-1:0] surv_addr;
  logic              tb_en;
  logic              tb_first;
  logic              tb_bit;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_bit;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, in_valid, rx_pair, tb_bit, dout_ready,
    output in_ready, bmc_rx_pair, metric_clr, acs_en, surv_wr_en, surv_addr,
           tb_en, tb_first, dout_valid, dout_bit, busy, frame_done
  );

  modport slave (
    output start, in_valid, rx_pair, tb_bit, dout_ready,
    input  in_ready, bmc_rx_pair, metric_clr, acs_en, surv_wr_en, surv_addr,
           tb_en, tb_first, dout_valid, dout_bit, busy, frame_done
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 Viterbi decoder: clear, ACS over the frame, traceback, then
// stream the decoded data bits (tail bits dropped). All outputs except in_ready are registered.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_frame_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ACS   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_TB    = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_BIT  = ADDR_W'(FRAME_LEN - 3);

  logic [2:0]           r_state,       w_state;
  logic [ADDR_W-1:0]    r_sym_cnt,     w_sym_cnt;
  logic [ADDR_W-1:0]    r_out_cnt,     w_out_cnt;
  logic [FRAME_LEN-1:0] r_obuf,        w_obuf;
  logic [1:0]           r_bmc_rx_pair, w_bmc_rx_pair;
  logic [ADDR_W-1:0]    r_surv_addr,   w_surv_addr;
  logic                 r_metric_clr,  w_metric_clr;
  logic                 r_acs_en,      w_acs_en;
  logic                 r_surv_wr_en,  w_surv_wr_en;
  logic                 r_tb_en,       w_tb_en;
  logic                 r_tb_first,    w_tb_first;
  logic                 r_dout_valid,  w_dout_valid;
  logic                 r_dout_bit,    w_dout_bit;
  logic                 r_busy,        w_busy;
  logic                 r_frame_done,  w_frame_done;
  logic [ADDR_W-1:0]    w_out_cnt_inc;

  assign w_out_cnt_inc = r_out_cnt + ADDR_W'(1);

  // Next state and next registered outputs
  always_comb begin
    w_state       = r_state;
    w_sym_cnt     = r_sym_cnt;
    w_out_cnt     = r_out_cnt;
    w_obuf        = r_obuf;
    w_bmc_rx_pair = r_bmc_rx_pair;
    w_surv_addr   = r_surv_addr;
    w_metric_clr  = 1'b0;
    w_acs_en      = 1'b0;
    w_surv_wr_en  = 1'b0;
    w_tb_en       = 1'b0;
    w_tb_first    = 1'b0;
    w_dout_valid  = 1'b0;
    w_dout_bit    = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state      = S_CLR;
          w_metric_clr = 1'b1;
        end
      end
      S_CLR: begin
        w_state   = S_ACS;
        w_sym_cnt = '0;
      end
      S_ACS: begin
        if (bus.in_valid) begin
          w_acs_en      = 1'b1;
          w_surv_wr_en  = 1'b1;
          w_surv_addr   = r_sym_cnt;
          w_bmc_rx_pair = bus.rx_pair;
          if (r_sym_cnt == LAST_STEP) begin
            w_state = S_DRAIN;
          end else begin
            w_sym_cnt = r_sym_cnt + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        w_state     = S_TB;
        w_tb_en     = 1'b1;
        w_tb_first  = 1'b1;
        w_surv_addr = LAST_STEP;
      end
      S_TB: begin
        w_obuf[r_surv_addr] = bus.tb_bit;
        // Stage 0's bit is forwarded straight into the first output word
        if (r_surv_addr == '0) begin
          w_state      = S_OUT;
          w_out_cnt    = '0;
          w_dout_valid = 1'b1;
          w_dout_bit   = bus.tb_bit;
        end else begin
          w_tb_en     = 1'b1;
          w_surv_addr = r_surv_addr - ADDR_W'(1);
        end
      end
      S_OUT: begin
        w_dout_valid = 1'b1;
        w_dout_bit   = r_dout_bit;
        if (bus.dout_ready) begin
          if (r_out_cnt == LAST_BIT) begin
            w_state      = S_IDLE;
            w_dout_valid = 1'b0;
            w_dout_bit   = 1'b0;
            w_frame_done = 1'b1;
          end else begin
            w_out_cnt  = w_out_cnt_inc;
            w_dout_bit = r_obuf[w_out_cnt_inc];
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sym_cnt     <= '0;
      r_out_cnt     <= '0;
      r_obuf        <= '0;
      r_bmc_rx_pair <= '0;
      r_surv_addr   <= '0;
      r_metric_clr  <= 1'b0;
      r_acs_en      <= 1'b0;
      r_surv_wr_en  <= 1'b0;
      r_tb_en       <= 1'b0;
      r_tb_first    <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_dout_bit    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_sym_cnt     <= w_sym_cnt;
      r_out_cnt     <= w_out_cnt;
      r_obuf        <= w_obuf;
      r_bmc_rx_pair <= w_bmc_rx_pair;
      r_surv_addr   <= w_surv_addr;
      r_metric_clr  <= w_metric_clr;
      r_acs_en      <= w_acs_en;
      r_surv_wr_en  <= w_surv_wr_en;
      r_tb_en       <= w_tb_en;
      r_tb_first    <= w_tb_first;
      r_dout_valid  <= w_dout_valid;
      r_dout_bit    <= w_dout_bit;
      r_busy        <= w_busy;
      r_frame_done  <= w_frame_done;
    end
  end

  assign bus.in_ready    = (r_state == S_ACS);
  assign bus.bmc_rx_pair = r_bmc_rx_pair;
  assign bus.metric_clr  = r_metric_clr;
  assign bus.acs_en      = r_acs_en;
  assign bus.surv_wr_en  = r_surv_wr_en;
  assign bus.surv_addr   = r_surv_addr;
  assign bus.tb_en       = r_tb_en;
  assign bus.tb_first    = r_tb_first;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.dout_bit    = r_dout_bit;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
endmodule
